// File: rtl/signed_div32_iter_if.sv
// Operand/result handshake bundle for signed_div32_iter.
// The master drives operands and consumes results; the slave is the divider.
interface signed_div32_iter_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] q;
   logic        out_valid;
   logic        out_ready;
   logic        div_by_zero;

   modport master (
      output a, b, in_valid, out_ready,
      input  in_ready, q, out_valid, div_by_zero
   );

   modport slave (
      input  a, b, in_valid, out_ready,
      output in_ready, q, out_valid, div_by_zero
   );
endinterface

// File: rtl/signed_div32_iter.sv
// Iterative radix-2 restoring signed divider, one quotient bit per cycle.
// q packs {remainder, quotient}; APPX_BITS skips the low quotient bits.
module signed_div32_iter #(
   parameter int APPX_BITS = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   signed_div32_iter_if.slave    bus,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

   localparam int N = 32 - APPX_BITS;

   state_t      state_q, state_d;
   logic [31:0] a_mag_q, a_mag_d;
   logic [31:0] b_mag_q, b_mag_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_q_q, sign_q_d;
   logic        sign_r_q, sign_r_d;
   logic [63:0] q_q, q_d;
   logic        dbz_q, dbz_d;

   logic [31:0] a_abs, b_abs;
   logic [4:0]  bit_idx;
   logic [32:0] shifted, trial;
   logic [31:0] quo_mag, quo_fix, rem_fix;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. in_ready is high only in IDLE, out_valid only in DONE; neither
   // depends combinationally on the other side's valid/ready.
   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.q           = q_q;
   assign bus.div_by_zero = dbz_q;
   assign dbg_state       = state_q;

   always_comb begin
      state_d  = state_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      q_d      = q_q;
      dbz_d    = dbz_q;

      a_abs   = bus.a[31] ? -bus.a : bus.a;
      b_abs   = bus.b[31] ? -bus.b : bus.b;
      // The counter runs N-1..0, so offsetting by APPX_BITS walks bits 31..APPX_BITS.
      bit_idx = cnt_q + 5'(APPX_BITS);
      shifted = {rem_q, a_mag_q[bit_idx]};
      trial   = shifted - {1'b0, b_mag_q};
      quo_mag = quo_q << APPX_BITS;
      quo_fix = sign_q_q ? -quo_mag : quo_mag;
      rem_fix = (APPX_BITS > 0) ? 32'd0 : (sign_r_q ? -rem_q : rem_q);

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_mag_d  = a_abs;
               b_mag_d  = b_abs;
               sign_q_d = bus.a[31] ^ bus.b[31];
               sign_r_d = bus.a[31];
               rem_d    = 32'd0;
               quo_d    = 32'd0;
               if (bus.b == 32'd0) begin
                  q_d     = {bus.a, 32'hFFFF_FFFF};
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  dbz_d   = 1'b0;
                  cnt_d   = 5'(N - 1);
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            rem_d = trial[32] ? shifted[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            q_d     = {rem_fix, quo_fix};
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_mag_q  <= 32'd0;
         b_mag_q  <= 32'd0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         cnt_q    <= 5'd0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         q_q      <= 64'd0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         q_q      <= q_d;
         dbz_q    <= dbz_d;
      end
   end

endmodule
